// File: rtl/lsu_rvdmem_if.sv
// -----------------------------------------------------------------------------
// lsu_rvdmem_if
// Bundles the three buses of the load/store unit:
//   req_*  : pipeline request (valid/ready), master -> slave
//   rsp_*  : registered response (valid/ready), slave -> master
//   mem_*  : single-port data memory, byte write enables, 1-cycle read latency
// The LSU is the slave of the pipeline side and drives the memory side.
// -----------------------------------------------------------------------------
interface lsu_rvdmem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [4:0]                req_rd;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic [4:0]                rsp_rd;
  logic                      rsp_we;
  logic                      rsp_err;

  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wen;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_we, rsp_err,
    input  rsp_ready,
    output mem_addr, mem_wdata, mem_wen,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_we, rsp_err,
    output rsp_ready,
    input  mem_addr, mem_wdata, mem_wen,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_rvdmem.sv
// -----------------------------------------------------------------------------
// lsu_rvdmem
// RV64 load/store unit driving a synchronous single-port data memory.
// One request at a time: stores write in the cycle after accept, loads read
// then extract/extend the addressed lanes into a registered response.
// Misaligned requests answer with err=1 and never touch memory.
// Ports:
//   clk    : clock, all state changes on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : lsu_rvdmem_if.slave (req_*, rsp_*, mem_* buses)
// Only DATA_WIDTH = 64 is supported.
//
// state  | meaning
// IDLE   | ready for a request (req_ready=1)
// ACCESS | memory address/wen/wdata presented; store writes here
// WAIT   | load data returning from memory, captured at next edge
// RESP   | response held until rsp_ready
// -----------------------------------------------------------------------------
module lsu_rvdmem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_rvdmem_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [2:0]  r_lane;

  logic        accept;
  logic        misaligned;
  logic [2:0]  lane;
  logic [7:0]  byte_mask;
  logic [63:0] data_mask;
  logic [7:0]  wen_lane;
  logic [63:0] wdata_lane;
  logic [63:0] rdata_shift;
  logic [63:0] load_ext;

  // Gated with rst_n so ready reads 0 for the whole reset interval.
  assign bus.req_ready = rst_n & (state == IDLE);
  assign accept        = bus.req_valid & (state == IDLE);
  assign lane          = bus.req_addr[2:0];

  // Request decode: alignment, byte enables and lane-shifted store data.
  always_comb begin
    misaligned = 1'b0;
    byte_mask  = 8'h01;
    unique case (bus.req_size)
      2'd0: begin misaligned = 1'b0;             byte_mask = 8'h01; end
      2'd1: begin misaligned = lane[0];          byte_mask = 8'h03; end
      2'd2: begin misaligned = |lane[1:0];       byte_mask = 8'h0f; end
      2'd3: begin misaligned = |lane;            byte_mask = 8'hff; end
    endcase
    data_mask = '0;
    for (int b = 0; b < 8; b++) begin
      data_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
    // Alignment guarantees the shifted mask never spills past lane 7.
    wen_lane   = byte_mask << lane;
    wdata_lane = (bus.req_wdata & data_mask) << {lane, 3'b000};
  end

  // Load extraction from the lanes captured at accept.
  always_comb begin
    rdata_shift = bus.mem_rdata >> {r_lane, 3'b000};
    load_ext    = rdata_shift;
    unique case (r_size)
      2'd0: load_ext = r_unsigned ? {56'd0, rdata_shift[7:0]}
                                  : {{56{rdata_shift[7]}}, rdata_shift[7:0]};
      2'd1: load_ext = r_unsigned ? {48'd0, rdata_shift[15:0]}
                                  : {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      2'd2: load_ext = r_unsigned ? {32'd0, rdata_shift[31:0]}
                                  : {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      2'd3: load_ext = rdata_shift;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS: state_nxt = r_we ? RESP : WAIT;
      WAIT:   state_nxt = RESP;
      RESP:   if (bus.rsp_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we          <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= 2'd0;
      r_lane        <= 3'd0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wen   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_rd    <= '0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // ACCESS lasts exactly one cycle, so enables only live for that cycle.
      bus.mem_wen   <= '0;
      bus.rsp_valid <= (state_nxt == RESP);

      if (accept) begin
        r_we          <= bus.req_we;
        r_unsigned    <= bus.req_unsigned;
        r_size        <= bus.req_size;
        r_lane        <= lane;
        bus.rsp_rd    <= bus.req_rd;
        bus.rsp_we    <= bus.req_we;
        bus.rsp_err   <= misaligned;
        bus.rsp_rdata <= '0;
        if (!misaligned) begin
          bus.mem_addr <= {3'b000, bus.req_addr[ADDR_WIDTH-1:3]};
          if (bus.req_we) begin
            bus.mem_wdata <= wdata_lane;
            bus.mem_wen   <= wen_lane;
          end
        end
      end

      if (state == WAIT) begin
        bus.rsp_rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rvdmem.sv
module tb_lsu_rvdmem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_rvdmem_if bus ();
  lsu_rvdmem dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: 64 doublewords, byte writes, one-cycle read latency.
  logic [63:0] mem [0:63];
  logic        mem_init = 1'b0;

  function automatic logic [63:0] init_val(input int i);
    if (i == 0)  return 64'hcafef00d55aa1234;
    if (i == 16) return 64'h0f0e0d0c0b0a0908;
    return 64'h0;
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
      bus.mem_rdata <= 64'h0;
    end else begin
      for (int b = 0; b < 8; b++)
        if (bus.mem_wen[b]) mem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    end
  end

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks latency on rsp_valid rise, pops and compares on handshake.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rd=%0d expected no response", bus.rsp_rd);
        end else if (q[0].lat >= 0) begin
          chk("rsp_latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
        end
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_rd",    64'(bus.rsp_rd), 64'(e.rd));
        chk("rsp_we",    64'(bus.rsp_we), 64'(e.we));
        chk("rsp_err",   64'(bus.rsp_err), 64'(e.err));
      end
      prev_valid <= bus.rsp_valid;
    end
  end

  logic watch = 1'b0;
  int   wen_bad = 0;
  always @(negedge clk) if (watch && bus.mem_wen != 8'h00) wen_bad <= wen_bad + 1;

  // Returns #1 after the accepting edge (DUT in ACCESS for aligned requests).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input logic [63:0] exp_rdata, input logic exp_err, input int lat,
                       input bit push);
    int n = 0;
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 addr=%h", addr);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (push) q.push_back('{exp_rdata, rd, we, exp_err, lat, cyc});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !bus.req_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: got pending=%0d expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0; bus.rsp_ready = 1;

    #12;
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_mem_wen",   64'(bus.mem_wen), 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1; #1;
    chk("ready_after_rst", 64'(bus.req_ready), 1);
    @(posedge clk); #1;

    // SW 0xdeadbeef @0x14
    issue(1, 2'd2, 0, 64'h14, 64'hdeadbeef, 5'd1, 64'h0, 0, 1, 1);
    chk("sw_mem_addr",  bus.mem_addr, 64'h2);
    chk("sw_mem_wen",   64'(bus.mem_wen), 64'hf0);
    chk("sw_mem_wdata", bus.mem_wdata, 64'hdeadbeef00000000);
    wait_done();

    // SD @0x40 then loads
    issue(1, 2'd3, 0, 64'h40, 64'h0123456789abcdef, 5'd2, 64'h0, 0, 1, 1);
    chk("sd_mem_wen",   64'(bus.mem_wen), 64'hff);
    chk("sd_mem_wdata", bus.mem_wdata, 64'h0123456789abcdef);
    wait_done();
    issue(0, 2'd1, 0, 64'h42, 64'h0, 5'd3, 64'hffffffffffff89ab, 0, 2, 1);
    chk("lh_mem_wen",  64'(bus.mem_wen), 64'h0);
    chk("lh_mem_addr", bus.mem_addr, 64'h8);
    wait_done();
    issue(0, 2'd1, 1, 64'h42, 64'h0, 5'd4, 64'h00000000000089ab, 0, 2, 1); wait_done();
    issue(0, 2'd2, 0, 64'h44, 64'h0, 5'd5, 64'h0000000001234567, 0, 2, 1); wait_done();
    issue(0, 2'd3, 0, 64'h40, 64'h0, 5'd6, 64'h0123456789abcdef, 0, 2, 1); wait_done();

    // SB 0x80 @0x17, then byte loads and the merged doubleword
    issue(1, 2'd0, 0, 64'h17, 64'hffffffffffffff80, 5'd9, 64'h0, 0, 1, 1);
    chk("sb_mem_wen",   64'(bus.mem_wen), 64'h80);
    chk("sb_mem_wdata", bus.mem_wdata, 64'h8000000000000000);
    wait_done();
    issue(0, 2'd0, 0, 64'h17, 64'h0, 5'd10, 64'hffffffffffffff80, 0, 2, 1); wait_done();
    issue(0, 2'd0, 1, 64'h17, 64'h0, 5'd11, 64'h0000000000000080, 0, 2, 1); wait_done();
    issue(0, 2'd3, 0, 64'h10, 64'h0, 5'd12, 64'h80adbeef00000000, 0, 2, 1); wait_done();

    // Misaligned accesses
    watch = 1'b1;
    issue(0, 2'd2, 0, 64'h6, 64'h0, 5'd13, 64'h0, 1, -1, 1); wait_done();
    issue(1, 2'd1, 0, 64'h3, 64'h1234, 5'd14, 64'h0, 1, -1, 1); wait_done();
    watch = 1'b0;
    chk("misaligned_no_wen", 64'(wen_bad), 0);
    issue(0, 2'd3, 0, 64'h0, 64'h0, 5'd15, 64'hcafef00d55aa1234, 0, 2, 1); wait_done();

    // Response backpressure
    bus.rsp_ready = 1'b0;
    issue(0, 2'd2, 0, 64'h44, 64'h0, 5'd7, 64'h0000000001234567, 0, 2, 1);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp", {bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_we, bus.rsp_rd, bus.rsp_rdata[31:0]},
          {1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h01234567});
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_ready", 64'(bus.req_ready), 1);
    wait_done();

    // Reset during WAIT of a load
    issue(0, 2'd3, 0, 64'h40, 64'h0, 5'd20, 64'h0, 0, 2, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rst_wait_outputs", {bus.rsp_valid, bus.req_ready, bus.mem_wen, bus.rsp_rdata, bus.mem_addr},
        {1'b0, 1'b0, 8'h00, 64'h0, 64'h0});
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during ACCESS of SD to 0x80
    issue(1, 2'd3, 0, 64'h80, 64'hffffffffffffffff, 5'd21, 64'h0, 0, 1, 0);
    chk("sd80_wen_before_rst", 64'(bus.mem_wen), 64'hff);
    rst_n = 1'b0; #1;
    chk("rst_access_outputs", {bus.rsp_valid, bus.req_ready, bus.mem_wen, bus.mem_wdata, bus.mem_addr},
        {1'b0, 1'b0, 8'h00, 64'h0, 64'h0});
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 2'd3, 0, 64'h80, 64'h0, 5'd18, 64'h0f0e0d0c0b0a0908, 0, 2, 1); wait_done();
    issue(0, 2'd3, 0, 64'h40, 64'h0, 5'd19, 64'h0123456789abcdef, 0, 2, 1); wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
